// File: rtl/npu_add_pkg.sv
// rtl/npu_add_pkg.sv - shared types and helpers for the MAC reduction-tree adders
// Purpose: rounding-mode encodings, the carry-save row type handed from the
//   compressor tree to the final adder, and a ceiling-divide helper for
//   segment sizing.
// Ports: none (package).
package npu_add_pkg;

   localparam logic RND_NONE    = 1'b0;
   localparam logic RND_HALF_UP = 1'b1;

   // Packages cannot be parametrised, so the row type is sized for the widest
   // tree; users zero-extend their IN_W-wide rows into it and slice back out.
   localparam int CSA_MAX_W = 64;

   typedef struct packed {
      logic [CSA_MAX_W-1:0] sum;
      logic [CSA_MAX_W-1:0] carry;
   } csa_row_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - one registered carry-chain slice of the final adder
// Purpose: adds two W-bit operand slices, a W-bit rounding slice and an
//   incoming carry, and registers the W-bit result and the carry-out.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (clears result/carry)
//   en             1 = load new result, 0 = hold
//   a, b           carry-save operand slices
//   rnd            rounding-constant slice (at most one bit set, in one slice only)
//   cin            carry from the slice below
//   sum            registered result bits
//   cout           registered carry to the slice above
module adder_seg #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] rnd,
   input  logic [1:0]   cin,
   output logic [W-1:0] sum,
   output logic [1:0]   cout
);

   // Three operands plus carry can reach 2^(W+1) + 2^(W-1), so the carry
   // between slices is two bits wide; it never exceeds 2.
   logic [W+1:0] total;

   assign total = (W+2)'(a) + (W+2)'(b) + (W+2)'(rnd) + (W+2)'(cin);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum  <= '0;
         cout <= '0;
      end else if (en) begin
         sum  <= total[W-1:0];
         cout <= total[W+1:W];
      end
   end

endmodule

// File: rtl/adder_final_pipe.sv
// rtl/adder_final_pipe.sv - pipelined carry-propagate adder closing the MAC reduction tree
// Purpose: adds the carry-save sum/carry rows plus an optional round-half-up
//   constant over SEGS registered carry segments, then drops the DROP low
//   result bits. Latency SEGS cycles, one beat per cycle, valid/ready flow.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid, in_ready    input handshake; in_ready = out_ready | ~out_valid
//   in_sum, in_carry      carry-save rows, IN_W bits each
//   in_rnd                1 = add 2^(DROP-1) before dropping bits
//   out_valid, out_ready  output handshake
//   out_data              result bits [IN_W-1:DROP]
//   out_cout              result bit IN_W
module adder_final_pipe
   import npu_add_pkg::*;
#(
   parameter int  IN_W  = 20,
   parameter int  DROP  = 6,
   parameter int  SEGS  = 2,
   localparam int OUT_W = IN_W - DROP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic [IN_W-1:0]  in_carry,
   input  logic             in_rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_cout
);

   localparam int SEG_W   = ceil_div(IN_W, SEGS);
   // Operands are zero-padded to a whole number of segments so every slice is
   // SEG_W wide; the padding only ever receives carries.
   localparam int PAD_W   = SEG_W * SEGS;
   localparam int RND_POS = (DROP > 0) ? DROP - 1 : 0;
   localparam logic [PAD_W-1:0] RND_BIT = PAD_W'(1) << RND_POS;

   logic             adv;
   csa_row_t         row;
   logic             unused_row;
   logic [PAD_W-1:0] sum_p, carry_p, rnd_p;
   logic [PAD_W+1:0] full;
   logic             unused_full;

   assign row.sum   = CSA_MAX_W'(in_sum);
   assign row.carry = CSA_MAX_W'(in_carry);
   assign unused_row = ^row;

   // Gate operands with in_valid so bubbles carry clean zeros down the pipe.
   assign sum_p   = in_valid ? row.sum[PAD_W-1:0]   : '0;
   assign carry_p = in_valid ? row.carry[PAD_W-1:0] : '0;
   assign rnd_p   = (in_valid && (DROP > 0) && (in_rnd == RND_HALF_UP)) ? RND_BIT : '0;

   for (genvar k = 0; k < SEGS; k++) begin : g_st
      // a_in/b_in/r_in are right-aligned: this stage's slice sits in [SEG_W-1:0].
      logic [PAD_W-1:0] a_in, b_in, r_in;
      logic [PAD_W-1:0] lo_in, lo_q, lo_out;
      logic [1:0]       c_in, cout_q;
      logic [SEG_W-1:0] res_q;
      logic             v_in, v_q;

      if (k == 0) begin : g_src0
         assign a_in  = sum_p;
         assign b_in  = carry_p;
         assign r_in  = rnd_p;
         assign lo_in = '0;
         assign c_in  = 2'b00;
         assign v_in  = in_valid;
      end else begin : g_srcn
         assign a_in  = g_st[k-1].g_sk.a_q;
         assign b_in  = g_st[k-1].g_sk.b_q;
         assign r_in  = g_st[k-1].g_sk.r_q;
         assign lo_in = g_st[k-1].lo_out;
         assign c_in  = g_st[k-1].cout_q;
         assign v_in  = g_st[k-1].v_q;
      end

      adder_seg #(.W(SEG_W)) u_seg (
         .clk     (clk),
         .reset_n (reset_n),
         .en      (adv),
         .a       (a_in[SEG_W-1:0]),
         .b       (b_in[SEG_W-1:0]),
         .rnd     (r_in[SEG_W-1:0]),
         .cin     (c_in),
         .sum     (res_q),
         .cout    (cout_q)
      );

      // Deskew: completed lower bits ride alongside this stage's result.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            v_q  <= 1'b0;
            lo_q <= '0;
         end else if (adv) begin
            v_q  <= v_in;
            lo_q <= lo_in;
         end
      end

      assign lo_out = lo_q | (PAD_W'(res_q) << (k * SEG_W));

      if (k < SEGS - 1) begin : g_sk
         // Skew: operand bits not yet added, shifted down one slice per stage.
         logic [PAD_W-1:0] a_q, b_q, r_q;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               a_q <= '0;
               b_q <= '0;
               r_q <= '0;
            end else if (adv) begin
               a_q <= a_in >> SEG_W;
               b_q <= b_in >> SEG_W;
               r_q <= r_in >> SEG_W;
            end
         end
      end else begin : g_last
         logic unused_hi;
         assign unused_hi = ^{a_in, b_in, r_in};
      end
   end

   assign out_valid = g_st[SEGS-1].v_q;
   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;

   // Full-precision result; bit IN_W is the carry-out whether it lands in the
   // padding of the top slice or in its carry register.
   assign full        = {g_st[SEGS-1].cout_q, g_st[SEGS-1].lo_out};
   assign out_data    = full[IN_W-1:DROP];
   assign out_cout    = full[IN_W];
   assign unused_full = ^full;

endmodule
